gf8_serial_mult: RTL and testbench



---
 rtl/gf8_serial_mult.sv | 148 ++++++++++++++
 tb/tb_gf8_serial_mult.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gf8_serial_mult.sv
// Bit-serial GF(2^3) multiplier, MSB-first over b, valid/ready on both sides.
// Optional build macro GF8_SELF_CHECK_EN adds a parallel cross-check flag chk_err.
module gf8_serial_mult #(
  parameter logic [2:0]  POLY = 3'b011,
  parameter int unsigned M    = 3
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [M-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef GF8_SELF_CHECK_EN
  ,
  output logic         chk_err
`endif
);

  localparam int unsigned CW = $clog2(M);

  if (M != 3) begin : g_bad_degree
    $error("gf8_serial_mult: field degree M must be 3");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   ra_q, ra_d, rb_q, rb_d, acc_q, acc_d, y_d, acc_mul;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_d, in_ready_d, busy_d;

  // Multiply by x, reducing the overflow bit with x^3 = POLY.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? M'(POLY) : '0);
  endfunction

  assign acc_mul = xtime(acc_q) ^ (rb_q[cnt_q] ? ra_q : '0);

`ifdef GF8_SELF_CHECK_EN
  logic chk_err_d;

  // Carry-less full product followed by explicit reduction, independent of the serial path.
  function automatic logic [M-1:0] par_mul(input logic [M-1:0] x, input logic [M-1:0] z);
    logic [2*M-2:0] p, t;
    logic [M-1:0]   zz;
    p  = '0;
    zz = z;
    for (int i = 0; i < M; i++) begin
      if (zz[0]) p = p ^ ((2*M-1)'(x) << i);
      zz = zz >> 1;
    end
    for (int k = 0; k < M - 1; k++) begin
      t = p >> (2*M-2-k);
      if (t[0]) p = p ^ ((2*M-1)'({1'b1, POLY}) << (M-2-k));
    end
    return p[M-1:0];
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;
    busy_d      = busy;
`ifdef GF8_SELF_CHECK_EN
    chk_err_d   = chk_err;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ra_d       = a;
          rb_d       = b;
          acc_d      = '0;
          cnt_d      = CW'(M - 1);
          state_d    = MUL;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MUL: begin
        acc_d = acc_mul;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          y_d         = acc_mul;
          state_d     = DONE;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      DONE: begin
`ifdef GF8_SELF_CHECK_EN
        chk_err_d = chk_err | (par_mul(ra_q, rb_q) != y);
`endif
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef GF8_SELF_CHECK_EN
      chk_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y         <= y_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
`ifdef GF8_SELF_CHECK_EN
      chk_err   <= chk_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf8_serial_mult.sv
// Directed self-checking bench for gf8_serial_mult with an expected-product scoreboard queue.
module tb_gf8_serial_mult;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] a, b, y;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
`ifdef GF8_SELF_CHECK_EN
  logic       chk_err;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];

  gf8_serial_mult dut (
    .Clk(Clk), .Rst(Rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef GF8_SELF_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden model for x^3+x+1: full carry-less product, then fold x^4 and x^3 back down.
  function automatic logic [2:0] gold(input logic [2:0] x, input logic [2:0] z);
    int p;
    p = 0;
    for (int j = 0; j < 3; j++) if (((int'(z) >> j) & 1) != 0) p = p ^ (int'(x) << j);
    for (int k = 4; k >= 3; k--) if (((p >> k) & 1) != 0) p = p ^ (11 << (k - 3));
    return 3'(p);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 8'(in_ready), 8'd1);
    chk({tag, "_out_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after completion.
  task automatic run_op(input logic [2:0] ta, input logic [2:0] tbv, input logic [2:0] ey,
                        input bit tog);
    int         lat;
    logic [2:0] e;
    chk("in_ready_before_op", 8'(in_ready), 8'd1);
    a = ta; b = tbv; in_valid = 1'b1;
    exp_q.push_back(ey);
    @(negedge Clk);
    in_valid = 1'b0;
    chk("busy_in_mul", 8'(busy), 8'd1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      if (tog) begin a = 3'($urandom); b = 3'($urandom); end
      @(negedge Clk);
      lat++;
    end
    chk("latency", 8'(lat), 8'd3);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (out_valid === 1'b1) chk("y", 8'(y), 8'(e));
    end
    if (out_ready) begin
      @(negedge Clk);
      chk_idle("after_op");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1; Rst = 1'b0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 Rst = 1'b1;
    #1;
    chk_idle("reset_async");
    chk("reset_y", 8'(y), 8'd0);
`ifdef GF8_SELF_CHECK_EN
    chk("reset_chk_err", 8'(chk_err), 8'd0);
`endif
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      chk_idle("idle_hold");
      chk("idle_y", 8'(y), 8'd0);
    end

    // Directed products.
    run_op(3'b010, 3'b100, 3'b011, 1'b0);
    run_op(3'b111, 3'b111, 3'b011, 1'b0);
    run_op(3'b101, 3'b011, 3'b100, 1'b0);
    run_op(3'b001, 3'b110, 3'b110, 1'b0);
    run_op(3'b000, 3'b111, 3'b000, 1'b0);

    // Operands toggling while busy must not disturb the captured pair.
    run_op(3'b110, 3'b101, gold(3'b110, 3'b101), 1'b1);

    // Backpressure: DONE holds y, and new requests are ignored.
    out_ready = 1'b0;
    run_op(3'b111, 3'b010, 3'b101, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = 3'($urandom); b = 3'($urandom); in_valid = 1'b1;
      @(negedge Clk);
      chk("bp_y", 8'(y), 8'd5);
      chk("bp_out_valid", 8'(out_valid), 8'd1);
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      chk("bp_busy", 8'(busy), 8'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge Clk);
    chk_idle("bp_release");
    chk("bp_y_retained", 8'(y), 8'd5);

    // Reset after the second MUL edge abandons the operation.
    a = 3'b011; b = 3'b111; in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk_idle("midop_reset");
    chk("midop_reset_y", 8'(y), 8'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      chk("midop_no_out_valid", 8'(out_valid), 8'd0);
    end
    run_op(3'b011, 3'b010, 3'b110, 1'b0);

    // Exhaustive, back-to-back.
    for (int i = 0; i < 64; i++) begin
      run_op(3'(i >> 3), 3'(i), gold(3'(i >> 3), 3'(i)), 1'b0);
`ifdef GF8_SELF_CHECK_EN
      chk("chk_err_clear", 8'(chk_err), 8'd0);
`endif
    end

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
